fancy_timer_ctrl: RTL and testbench

Complete controller for the pattern-triggered delay timer. It searches a serial stream for 1101, shifts in a 4-bit delay value MSB-first, counts down (delay+1)*CYCLES_PER_UNIT cycles, then holds done until the host acknowledges. It contains both the sequencing FSM and the shift, countdown and prescaler datapath, and sits between the serial input pin and the host handshake.

---
 rtl/fancy_timer_pkg.sv | 50 +++++
 rtl/fancy_timer_prescaler.sv | 29 ++
 rtl/fancy_timer_ctrl.sv | 94 +++++++++
 tb/tb_fancy_timer_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fancy_timer_pkg.sv
// Shared constants, state encoding and the pattern-search helper for the
// pattern-triggered delay timer.
package fancy_timer_pkg;

    localparam int unsigned DEF_CYCLES_PER_UNIT = 1000;
    localparam int unsigned DEF_DELAY_W         = 4;
    localparam logic [3:0]  PATTERN             = 4'b1101;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_S1    = 3'd1;
    localparam logic [2:0] ST_S11   = 3'd2;
    localparam logic [2:0] ST_S110  = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_COUNT = 3'd5;
    localparam logic [2:0] ST_WAIT  = 3'd6;

    // Search states encode the number of pattern bits matched so far (0..3).
    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        S1    = ST_S1,
        S11   = ST_S11,
        S110  = ST_S110,
        SHIFT = ST_SHIFT,
        COUNT = ST_COUNT,
        WAIT  = ST_WAIT
    } state_t;

    // Overlapping-search step: given `len` matched bits and a new bit, return
    // the longest suffix that is still a prefix of `pat` (4 means full match).
    function automatic logic [2:0] pat_advance(
        input logic [3:0] pat,
        input logic [2:0] len,
        input logic       b
    );
        int unsigned p;
        int unsigned l;
        int unsigned s;
        int unsigned best;
        p    = 32'(pat);
        l    = 32'(len);
        s    = ((p >> (4 - l)) << 1) | 32'(b);
        best = 0;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (k <= l + 1 && (s & ((32'd1 << k) - 1)) == (p >> (4 - k)))
                best = k;
        end
        return 3'(best);
    endfunction

endpackage

// File: rtl/fancy_timer_prescaler.sv
// Mod-N prescaler: counts 0..N-1 while enabled and ticks at the terminal value.
module fancy_timer_prescaler
    import fancy_timer_pkg::*;
#(
    parameter int unsigned N = DEF_CYCLES_PER_UNIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] TERM = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == TERM);

endmodule

// File: rtl/fancy_timer_ctrl.sv
// Pattern-triggered delay timer: finds PATTERN in the serial stream, shifts in
// a delay, counts (delay+1) units, then holds done until acknowledged.
module fancy_timer_ctrl #(
    parameter int unsigned CYCLES_PER_UNIT = fancy_timer_pkg::DEF_CYCLES_PER_UNIT,
    parameter int unsigned DELAY_W         = fancy_timer_pkg::DEF_DELAY_W,
    parameter logic [3:0]  PATTERN         = fancy_timer_pkg::PATTERN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    output logic [DELAY_W-1:0] count,
    output logic               counting,
    output logic               done
);

    import fancy_timer_pkg::*;

    localparam int unsigned     BC_W     = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DELAY_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [DELAY_W-1:0] delay_q;
    logic [BC_W-1:0]    bit_cnt;
    logic [2:0]         search_len;
    logic [2:0]         match_nxt;
    logic               tick;
    logic               in_count;

    assign in_count = (state == COUNT);

    fancy_timer_prescaler #(
        .N(CYCLES_PER_UNIT)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(!in_count),
        .en   (in_count),
        .tick (tick)
    );

    assign search_len = state;
    assign match_nxt  = pat_advance(PATTERN, search_len, data);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, S1, S11, S110: begin
                state_nxt = (match_nxt == 3'd4) ? SHIFT : state_t'(match_nxt);
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT)
                    state_nxt = COUNT;
            end
            COUNT: begin
                if (tick && delay_q == '0)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            delay_q <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                SHIFT: begin
                    delay_q <= {delay_q[DELAY_W-2:0], data};
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                end
                COUNT: begin
                    // The final unit leaves delay_q at 0, so WAIT shows count=0.
                    if (tick && delay_q != '0)
                        delay_q <= delay_q - 1'b1;
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    assign count    = delay_q;
    assign counting = in_count;
    assign done     = (state == WAIT);

endmodule

// File: tb/tb_fancy_timer_ctrl.sv
// Self-checking bench: two timers (1000 and 4 cycles per unit) driven with
// directed and random streams, checked against a window-based reference model.
module tb_fancy_timer_ctrl;

    localparam int unsigned DW    = 4;
    localparam int unsigned CPU_A = 1000;
    localparam int unsigned CPU_B = 4;
    localparam logic [3:0]  PAT   = 4'b1101;

    logic          clk = 1'b0;
    logic          reset_a, data_a, ack_a;
    logic          reset_b, data_b, ack_b;
    logic [DW-1:0] count_a, count_b;
    logic          counting_a, done_a, counting_b, done_b;

    int checks = 0;
    int errors = 0;
    int unsigned win   [2];
    int unsigned nbits [2];

    always #5 clk = ~clk;

    fancy_timer_ctrl dut_a (
        .clk(clk), .reset(reset_a), .data(data_a), .ack(ack_a),
        .count(count_a), .counting(counting_a), .done(done_a)
    );

    fancy_timer_ctrl #(.CYCLES_PER_UNIT(CPU_B)) dut_b (
        .clk(clk), .reset(reset_b), .data(data_b), .ack(ack_b),
        .count(count_b), .counting(counting_b), .done(done_b)
    );

    function automatic int unsigned cpu(input int unsigned u);
        return (u == 0) ? CPU_A : CPU_B;
    endfunction

    function automatic logic [DW-1:0] get_count(input int unsigned u);
        return (u == 0) ? count_a : count_b;
    endfunction

    function automatic logic get_counting(input int unsigned u);
        return (u == 0) ? counting_a : counting_b;
    endfunction

    function automatic logic get_done(input int unsigned u);
        return (u == 0) ? done_a : done_b;
    endfunction

    task automatic drive(input int unsigned u, input logic r, input logic d, input logic a);
        if (u == 0) begin
            reset_a = r; data_a = d; ack_a = a;
        end else begin
            reset_b = r; data_b = d; ack_b = a;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a fresh search keeps the last four stream bits.
    task automatic model_restart(input int unsigned u);
        win[u]   = 0;
        nbits[u] = 0;
    endtask

    task automatic model_push(input int unsigned u, input logic b, output bit hit);
        win[u]   = ((win[u] << 1) | 32'(b)) & 32'hF;
        nbits[u] = nbits[u] + 1;
        hit      = (nbits[u] >= 4) && (win[u] == 32'(PAT));
    endtask

    task automatic feed_search(input int unsigned u, input logic b, output bit hit);
        drive(u, 1'b0, b, 1'b0);
        cyc();
        model_push(u, b, hit);
        checks++;
        if (get_counting(u) !== 1'b0 || get_done(u) !== 1'b0 || get_count(u) !== '0) begin
            errors++;
            $display("FAIL search_idle u%0d: got counting=%b done=%b count=%0d, want 0 0 0",
                     u, get_counting(u), get_done(u), get_count(u));
        end
    endtask

    task automatic feed_list(input int unsigned u, input logic [15:0] bits, input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < n && !hit; i++)
            feed_search(u, bits[n-1-i], hit);
    endtask

    task automatic shift_delay(input int unsigned u, input logic [3:0] d);
        logic [3:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(u, 1'b0, d[3-i], 1'b0);
            cyc();
            exp = d >> (3 - i);
            checks++;
            if (i < 3) begin
                if (get_counting(u) !== 1'b0 || get_count(u) !== exp) begin
                    errors++;
                    $display("FAIL shift_partial u%0d bit%0d: got counting=%b count=%0d, want 0 %0d",
                             u, i, get_counting(u), get_count(u), exp);
                end
            end else begin
                if (get_counting(u) !== 1'b1 || get_count(u) !== d) begin
                    errors++;
                    $display("FAIL count_start u%0d: got counting=%b count=%0d, want 1 %0d",
                             u, get_counting(u), get_count(u), d);
                end
            end
        end
    endtask

    task automatic run_count(input int unsigned u, input logic [3:0] d, input bit noise);
        int unsigned k, bad, lim, bad_k;
        int exp_i;
        logic [DW-1:0] bad_v;
        k = 0; bad = 0; bad_k = 0; bad_v = '0;
        lim = 17 * cpu(u) + 8;
        while (get_counting(u) === 1'b1 && k < lim) begin
            exp_i = int'(d) - int'(k / cpu(u));
            if (get_count(u) !== DW'(exp_i) || get_done(u) !== 1'b0) begin
                if (bad == 0) begin
                    bad_k = k;
                    bad_v = get_count(u);
                end
                bad++;
            end
            drive(u, 1'b0, 1'($urandom_range(1, 0)), noise ? 1'($urandom_range(1, 0)) : 1'b0);
            k++;
            cyc();
        end
        drive(u, 1'b0, 1'b0, 1'b0);
        checks++;
        if (k != (32'(d) + 1) * cpu(u)) begin
            errors++;
            $display("FAIL count_len u%0d: got %0d counting cycles, want %0d",
                     u, k, (32'(d) + 1) * cpu(u));
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL count_profile u%0d: %0d bad cycles, first at k=%0d got count=%0d want %0d",
                     u, bad, bad_k, bad_v, int'(d) - int'(bad_k / cpu(u)));
        end
        checks++;
        if (get_done(u) !== 1'b1 || get_count(u) !== '0 || get_counting(u) !== 1'b0) begin
            errors++;
            $display("FAIL wait_entry u%0d: got done=%b count=%0d counting=%b, want 1 0 0",
                     u, get_done(u), get_count(u), get_counting(u));
        end
    endtask

    task automatic wait_hold(input int unsigned u, input int n);
        logic [3:0] pat_v;
        pat_v = PAT;
        for (int i = 0; i < n; i++) begin
            drive(u, 1'b0, pat_v[3 - (i % 4)], 1'b0);
            cyc();
            checks++;
            if (get_done(u) !== 1'b1 || get_counting(u) !== 1'b0 || get_count(u) !== '0) begin
                errors++;
                $display("FAIL wait_hold u%0d cyc%0d: got done=%b counting=%b count=%0d, want 1 0 0",
                         u, i, get_done(u), get_counting(u), get_count(u));
            end
        end
    endtask

    task automatic do_ack(input int unsigned u);
        drive(u, 1'b0, 1'b0, 1'b1);
        cyc();
        drive(u, 1'b0, 1'b0, 1'b0);
        checks++;
        if (get_done(u) !== 1'b0 || get_counting(u) !== 1'b0 || get_count(u) !== '0) begin
            errors++;
            $display("FAIL ack_release u%0d: got done=%b counting=%b count=%0d, want 0 0 0",
                     u, get_done(u), get_counting(u), get_count(u));
        end
        model_restart(u);
    endtask

    task automatic check_zero(input int unsigned u, input string name);
        checks++;
        if (get_done(u) !== 1'b0 || get_counting(u) !== 1'b0 || get_count(u) !== '0) begin
            errors++;
            $display("FAIL %s u%0d: got done=%b counting=%b count=%0d, want 0 0 0",
                     name, u, get_done(u), get_counting(u), get_count(u));
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 1'b1, 1'b1);
        drive(1, 1'b1, 1'b1, 1'b1);
        repeat (3) cyc();
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        check_zero(0, "reset_state");
        check_zero(1, "reset_state");
        model_restart(0);
        model_restart(1);
    endtask

    task automatic test_basic();
        feed_list(0, 16'b1101, 4);
        shift_delay(0, 4'd5);
        run_count(0, 4'd5, 1'b0);
        wait_hold(0, 20);
        do_ack(0);
    endtask

    task automatic test_overlap();
        feed_list(0, 16'b111101, 6);
        shift_delay(0, 4'd0);
        run_count(0, 4'd0, 1'b0);
        wait_hold(0, 2);
        do_ack(0);
    endtask

    task automatic test_near_miss();
        feed_list(1, 16'b1011001101, 10);
        shift_delay(1, 4'b1011);
        run_count(1, 4'b1011, 1'b0);
        do_ack(1);
    endtask

    task automatic test_ack_ignored();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b0, 1'b0, 1'b1);
            cyc();
            check_zero(1, "ack_idle");
        end
        drive(1, 1'b0, 1'b0, 1'b0);
        feed_list(1, 16'b1101, 4);
        shift_delay(1, 4'b0010);
        run_count(1, 4'b0010, 1'b1);
        wait_hold(1, 20);
        do_ack(1);
    endtask

    task automatic test_reset_mid();
        int unsigned n;
        feed_list(0, 16'b1101, 4);
        shift_delay(0, 4'd4);
        n = 0;
        while (get_count(0) !== 4'd3 && n < 3000) begin
            drive(0, 1'b0, 1'($urandom_range(1, 0)), 1'b0);
            cyc();
            n++;
        end
        checks++;
        if (get_count(0) !== 4'd3 || get_counting(0) !== 1'b1) begin
            errors++;
            $display("FAIL reach_count3 u0: got count=%0d counting=%b after %0d cycles, want 3 1",
                     get_count(0), get_counting(0), n);
        end
        drive(0, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(0, 1'b0, 1'b0, 1'b0);
        check_zero(0, "reset_mid_count");
        model_restart(0);
        feed_list(0, 16'b1101, 4);
        shift_delay(0, 4'b0001);
        run_count(0, 4'b0001, 1'b0);
        do_ack(0);
    endtask

    task automatic test_reset_last();
        feed_list(1, 16'b1101, 4);
        shift_delay(1, 4'd0);
        repeat (CPU_B - 1) cyc();
        checks++;
        if (get_counting(1) !== 1'b1) begin
            errors++;
            $display("FAIL last_count_cycle u1: got counting=%b, want 1", get_counting(1));
        end
        drive(1, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1, 1'b0, 1'b0, 1'b0);
        check_zero(1, "reset_last_cycle");
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_zero(1, "no_done_after_reset");
        end
        model_restart(1);
    endtask

    task automatic test_max();
        feed_list(1, 16'b1101, 4);
        shift_delay(1, 4'b1111);
        run_count(1, 4'b1111, 1'b1);
        do_ack(1);
    endtask

    task automatic test_random();
        bit hit;
        logic [3:0] d;
        logic [3:0] pat_v;
        int n;
        pat_v = PAT;
        for (int it = 0; it < 12; it++) begin
            hit = 1'b0;
            n = 0;
            while (!hit && n < 64) begin
                feed_search(1, 1'($urandom_range(1, 0)), hit);
                n++;
            end
            for (int i = 0; i < 4 && !hit; i++)
                feed_search(1, pat_v[3-i], hit);
            d = 4'($urandom_range(15, 0));
            shift_delay(1, d);
            run_count(1, d, 1'b1);
            wait_hold(1, int'($urandom_range(5, 0)));
            do_ack(1);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_ack_ignored();
        test_reset_mid();
        test_reset_last();
        test_max();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
